fb_rect_writer: RTL and testbench
=================================

Name: fb_rect_writer

Overview:
- Drawing engine that fills the back framebuffer; it is the write side of the double-buffered 160x120 VGA display.
- Accepts rectangle-fill and clear commands over a valid/ready handshake and writes 24-bit RGB words into the framebuffer write port.
- Addressing is column-major: addr = x*120 + y.
- After each command completes, it waits for the next frame boundary and pulses buf_swap so the display flips buffers.

Parameters:
- FB_W, 160, virtual framebuffer width in words
- FB_H, 120, virtual framebuffer height in words
- ADDR_W, 15, framebuffer address width
- COLOR_W, 24, pixel word width {R,G,B}

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_clear  in  1  1 = fill the whole buffer; cmd_x/y/w/h are ignored
- cmd_x  in  8  left column, 0..159
- cmd_y  in  7  top row, 0..119
- cmd_w  in  8  width in words
- cmd_h  in  7  height in words
- cmd_color  in  24  fill colour
- frame_done  in  1  level from vga_driver, high outside the active frame
- mem_address  out  ADDR_W  framebuffer write address
- mem_data  out  COLOR_W  framebuffer write data
- mem_wren  out  1  write strobe; one word per cycle while high
- busy  out  1  high in any state other than IDLE
- buf_swap  out  1  one-cycle pulse requesting a buffer flip
- cmd_error  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset values (synchronous, active-high): state IDLE, cmd_ready=1 once reset is released, and all other outputs 0.
- If rst asserts mid-operation, mem_wren is 0 on the next edge and the remaining writes are abandoned.
- Handshake:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready.
  - All cmd_* fields are latched on that edge.
  - cmd_ready drops on the following cycle.
- State machine:
  - IDLE -> SETUP on accept.
  - SETUP:
    - Resolves the rectangle. cmd_clear forces x0=0, y0=0, w=FB_W, h=FB_H.
    - If w==0 or h==0, goes to WAIT_FRAME with no writes.
    - Range violations are handled per the optional feature.
    - Otherwise computes col_base = x0*FB_H + y0 and goes to WRITE.
  - WRITE:
    - mem_wren=1 and mem_data=color.
    - The inner loop walks rows cy=0..h-1 with address col_base+cy.
    - At cy==h-1, cx increments and col_base advances by FB_H.
    - After the last word (cx==w-1, cy==h-1), goes to WAIT_FRAME. mem_wren is 0 from that next cycle.
  - WAIT_FRAME: waits for a rising edge of frame_done (frame_done registered, rise = frame_done & ~prev). A frame_done that is already high on entry does not count.
  - SWAP: buf_swap=1 for one cycle, then IDLE.
- Latency:
  - Accept at edge T, SETUP in cycle T+1, first write in cycle T+2.
  - A rectangle takes exactly w*h write cycles.
  - Full clear takes 19200 write cycles.
- Arithmetic:
  - Address math is 15-bit unsigned.
  - x0+w and y0+h are evaluated 9-bit/8-bit to avoid wrap.
  - Maximum address is 19199.
- Boundaries:
  - cmd_valid while busy is ignored; it is not queued.
  - A frame_done rise during WRITE is ignored.
  - Only a rise in WAIT_FRAME causes a swap.

Optional Feature:
- Macro: FB_RECT_WRITER_CLIP_EN.
- Defined: rectangles are clipped in SETUP.
  - w_eff = min(w, FB_W-x0), h_eff = min(h, FB_H-y0).
  - If x0>=FB_W or y0>=FB_H, the command degenerates to zero size (no writes, swap still occurs).
  - cmd_error is never asserted.
- Undefined:
  - If x0+w>FB_W or y0+h>FB_H, SETUP pulses cmd_error for one cycle and returns to IDLE.
  - No writes and no buf_swap occur in that case.

Decomposition:
- Shared package fb_pkg holds:
  - FB_W/FB_H constants and FB_WORDS=19200
  - the state encoding (IDLE, SETUP, WRITE, WAIT_FRAME, SWAP)
  - the colour word width
  - the address helper function x*FB_H+y
- One sub-module, fb_edge_detect, gives a registered rising-edge detector on frame_done, with synchronous reset.

Test Plan:
- Rect x=2, y=3, w=2, h=2, colour FF0000:
  - Writes addresses 243, 244, 363, 364 in order, first at T+2, mem_wren high exactly 4 cycles.
  - After the next frame_done rise, a single buf_swap pulse follows.
- cmd_clear=1, colour 000000: 19200 consecutive writes, addresses 0..19199; busy falls after the SWAP cycle.
- Rect x=158, y=0, w=4, h=1:
  - With CLIP_EN, writes only 18960 and 19080.
  - Without CLIP_EN, cmd_error pulses and there are no writes and no swap.
- w=0: no writes; the command still waits for the frame_done rise and swaps.
- rst=1 asserted on the 10th write cycle of a clear:
  - mem_wren is 0 at the next edge and the block is in IDLE.
  - cmd_ready=1 after rst drops.
- frame_done held high when WAIT_FRAME is entered: no swap until it falls and rises again; cmd_valid pulses during busy are ignored.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, state encoding and address helper for the framebuffer rectangle writer.
// Column-major framebuffer: addr = x*FB_H + y.
package fb_pkg;

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned COLOR_W  = 24;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWrite,
        StWaitFrame,
        StSwap
    } fb_state_e;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(x) * ADDR_W'(FB_H) + ADDR_W'(y);
    endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake and framebuffer write port of the rectangle writer.
// slave = drawing engine side, master = command issuer / memory side.
interface fb_rect_writer_if;
    import fb_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_clear;
    logic [7:0]         cmd_x;
    logic [6:0]         cmd_y;
    logic [7:0]         cmd_w;
    logic [6:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic [ADDR_W-1:0]  mem_address;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_wren;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, mem_address, mem_data, mem_wren
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, mem_address, mem_data, mem_wren
    );

endinterface

// File: rtl/fb_edge_detect.sv
// Registered rising-edge detector for the frame_done level from the VGA driver.
module fb_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= level;
            prev_q  <= level_q;
        end
    end

    assign rise = level_q & ~prev_q;

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / clear engine for the back framebuffer; flips buffers on the next frame.
// FB_RECT_WRITER_CLIP_EN: clip oversized rectangles instead of rejecting them.
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fb_rect_writer_if.slave   bus,
    input  logic              frame_done,
    output logic              busy,
    output logic              buf_swap,
    output logic              cmd_error
);

    localparam logic [7:0]        FbW8 = 8'(FB_W);
    localparam logic [6:0]        FbH7 = 7'(FB_H);
    localparam logic [ADDR_W-1:0] FbHA = ADDR_W'(FB_H);

    fb_state_e          state_q, state_d;
    logic               clr_q;
    logic [7:0]         x_q, w_q, wlen_q, wlen_d, cx_q, cx_d;
    logic [6:0]         y_q, h_q, hlen_q, hlen_d, cy_q, cy_d;
    logic [COLOR_W-1:0] color_q;
    logic [ADDR_W-1:0]  base_q, base_d;

    logic       accept;
    logic       frame_rise;
    logic       writing;
    logic [7:0] x0, w_r, w_eff;
    logic [6:0] y0, h_r, h_eff;
    logic       range_err;

    fb_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (frame_done),
        .rise  (frame_rise)
    );

    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign writing = (state_q == StWrite);

    assign bus.cmd_ready   = (state_q == StIdle) && !rst;
    assign bus.mem_wren    = writing;
    assign bus.mem_address = writing ? base_q + ADDR_W'(cy_q) : '0;
    assign bus.mem_data    = writing ? color_q : '0;
    assign busy            = (state_q != StIdle);
    assign buf_swap        = (state_q == StSwap);

    // Rectangle resolution, consumed only in SETUP.
    assign x0  = clr_q ? 8'd0 : x_q;
    assign y0  = clr_q ? 7'd0 : y_q;
    assign w_r = clr_q ? FbW8 : w_q;
    assign h_r = clr_q ? FbH7 : h_q;

`ifdef FB_RECT_WRITER_CLIP_EN
    logic [7:0] x_room;
    logic [6:0] y_room;

    assign x_room    = (x0 < FbW8) ? FbW8 - x0 : 8'd0;
    assign y_room    = (y0 < FbH7) ? FbH7 - y0 : 7'd0;
    assign w_eff     = (w_r < x_room) ? w_r : x_room;
    assign h_eff     = (h_r < y_room) ? h_r : y_room;
    assign range_err = 1'b0;
`else
    logic [8:0] x_end;
    logic [7:0] y_end;

    // One extra bit so x0+w and y0+h cannot wrap.
    assign x_end     = {1'b0, x0} + {1'b0, w_r};
    assign y_end     = {1'b0, y0} + {1'b0, h_r};
    assign w_eff     = w_r;
    assign h_eff     = h_r;
    assign range_err = (x_end > {1'b0, FbW8}) || (y_end > {1'b0, FbH7});
`endif

    always_comb begin
        state_d   = state_q;
        wlen_d    = wlen_q;
        hlen_d    = hlen_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        base_d    = base_q;
        cmd_error = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StSetup;
            end
            StSetup: begin
                if (w_eff == 8'd0 || h_eff == 7'd0) begin
                    state_d = StWaitFrame;
                end else if (range_err) begin
                    cmd_error = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wlen_d  = w_eff;
                    hlen_d  = h_eff;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    base_d  = fb_addr(x0, y0);
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (cy_q == hlen_q - 7'd1) begin
                    cy_d   = 7'd0;
                    base_d = base_q + FbHA;
                    if (cx_q == wlen_q - 8'd1) state_d = StWaitFrame;
                    else                       cx_d    = cx_q + 8'd1;
                end else begin
                    cy_d = cy_q + 7'd1;
                end
            end
            StWaitFrame: begin
                if (frame_rise) state_d = StSwap;
            end
            StSwap: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            clr_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            wlen_q  <= '0;
            hlen_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            wlen_q  <= wlen_d;
            hlen_q  <= hlen_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            base_q  <= base_d;
            if (accept) begin
                clr_q   <= bus.cmd_clear;
                x_q     <= bus.cmd_x;
                y_q     <= bus.cmd_y;
                w_q     <= bus.cmd_w;
                h_q     <= bus.cmd_h;
                color_q <= bus.cmd_color;
            end
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer; honours FB_RECT_WRITER_CLIP_EN in its reference model.
module tb_fb_rect_writer;
    import fb_pkg::*;

    localparam int W = FB_W;
    localparam int H = FB_H;
    localparam int KWr = 0, KSwap = 1, KErr = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_done = 1'b0;
    logic busy, buf_swap, cmd_error;

    fb_rect_writer_if bus ();

    fb_rect_writer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy),
        .buf_swap   (buf_swap),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  writes_seen = 0;
    int  swaps_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_event(input int kind, input int addr, input int data);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected event: got kind %0d addr %0d, required none", kind, addr);
        end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event kind", kind, e.kind);
            if (kind == KWr && e.kind == KWr) begin
                chk("write addr", addr, e.addr);
                chk("write data", data, e.data);
            end
        end
    endtask

    // Monitor: every output event is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_wren === 1'b1) begin
                writes_seen++;
                check_event(KWr, int'(bus.mem_address), int'(bus.mem_data));
            end
            if (buf_swap === 1'b1) begin
                swaps_seen++;
                check_event(KSwap, 0, 0);
            end
            if (cmd_error === 1'b1) check_event(KErr, 0, 0);
        end
    end

    // Reference model: what a command should produce, straight from the rules.
    task automatic model(input bit clr, input int x, input int y, input int w, input int h,
                         input int color, output bit err, output int nw);
        int x0, y0, ww, hh;
        x0 = x; y0 = y; ww = w; hh = h;
        err = 1'b0;
        nw  = 0;
        if (clr) begin
            x0 = 0; y0 = 0; ww = W; hh = H;
        end
`ifdef FB_RECT_WRITER_CLIP_EN
        if (x0 >= W || y0 >= H) begin
            ww = 0; hh = 0;
        end else begin
            if (ww > W - x0) ww = W - x0;
            if (hh > H - y0) hh = H - y0;
        end
`else
        if (ww != 0 && hh != 0 && (x0 + ww > W || y0 + hh > H)) err = 1'b1;
`endif
        if (err) begin
            exp_q.push_back(ev_t'{KErr, 0, 0});
        end else begin
            for (int cx = x0; cx < x0 + ww; cx++)
                for (int cy = y0; cy < y0 + hh; cy++) begin
                    exp_q.push_back(ev_t'{KWr, cx * H + cy, color});
                    nw++;
                end
            exp_q.push_back(ev_t'{KSwap, 0, 0});
        end
    endtask

    task automatic send(input bit clr, input int x, input int y, input int w, input int h,
                        input int color);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready before send", bus.cmd_ready, 1);
        bus.cmd_clear = clr;
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 7'(y);
        bus.cmd_w     = 8'(w);
        bus.cmd_h     = 7'(h);
        bus.cmd_color = 24'(color);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic issue(input bit clr, input int x, input int y, input int w, input int h,
                         input int color, output bit err, output int nw);
        model(clr, x, y, w, h, color, err, nw);
        send(clr, x, y, w, h, color);
    endtask

    task automatic wait_drain(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() > target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size() <= target, 1);
        if (exp_q.size() > target) exp_q.delete();
    endtask

    task automatic finish_cmd(input bit err, input int nw);
        if (err) begin
            wait_drain(0, 20, "error pulse seen");
            @(negedge clk);
            #1;
            chk("idle after error", busy, 0);
            chk("ready after error", bus.cmd_ready, 1);
        end else begin
            wait_drain(1, nw + 50, "writes done");
            repeat (3) @(negedge clk);
            frame_done = 1'b1;
            wait_drain(0, 20, "swap seen");
            chk("busy during swap", busy, 1);
            @(negedge clk);
            #1;
            frame_done = 1'b0;
            chk("idle after swap", busy, 0);
            chk("ready after swap", bus.cmd_ready, 1);
        end
    endtask

    initial begin
        bit err;
        int nw, s0, w0, n;

        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_color = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_wren", bus.mem_wren, 0);
        chk("reset mem_address", bus.mem_address, 0);
        chk("reset busy", busy, 0);
        chk("reset buf_swap", buf_swap, 0);
        chk("reset cmd_error", cmd_error, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready after reset", bus.cmd_ready, 1);

        // Directed rectangle with latency checks.
        issue(1'b0, 2, 3, 2, 2, 24'hFF0000, err, nw);
        @(negedge clk);
        chk("setup cycle no write", bus.mem_wren, 0);
        chk("setup cycle busy", busy, 1);
        @(negedge clk);
        chk("first write at T+2", bus.mem_wren, 1);
        chk("first write addr", bus.mem_address, 243);
        finish_cmd(err, nw);

        // Right-edge rectangle: clipped or rejected depending on build.
        issue(1'b0, 158, 0, 4, 1, 24'h00FF00, err, nw);
        finish_cmd(err, nw);

        // Zero width still swaps.
        issue(1'b0, 10, 10, 0, 5, 24'h123456, err, nw);
        finish_cmd(err, nw);

        // frame_done already high on entry to WAIT_FRAME; stray command while busy.
        frame_done = 1'b1;
        issue(1'b0, 5, 5, 3, 2, 24'h0000FF, err, nw);
        @(negedge clk);
        @(negedge clk);
        bus.cmd_x = 8'd0;
        bus.cmd_y = 7'd0;
        bus.cmd_w = 8'd1;
        bus.cmd_h = 7'd1;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_drain(1, 50, "held writes done");
        s0 = swaps_seen;
        repeat (20) @(negedge clk);
        #1;
        chk("no swap while frame_done held", swaps_seen, s0);
        chk("still busy while held", busy, 1);
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        frame_done = 1'b1;
        wait_drain(0, 20, "swap after re-rise");
        @(negedge clk);
        #1;
        frame_done = 1'b0;
        chk("idle after held test", busy, 0);

        // Randomized commands, biased toward the right and bottom edges.
        for (int i = 0; i < 25; i++) begin
            int rx, ry, rw, rh;
            rx = (i % 3 == 0) ? int'($urandom_range(150, 165)) : int'($urandom_range(0, 170));
            ry = (i % 4 == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
            rw = int'($urandom_range(0, 8));
            rh = int'($urandom_range(0, 8));
            issue(1'b0, rx, ry, rw, rh, int'($urandom_range(0, 24'hFFFFFF)), err, nw);
            finish_cmd(err, nw);
        end

        // Full clear ignores the rectangle fields.
        issue(1'b1, 7, 9, 3, 3, 24'h000000, err, nw);
        chk("clear word count", nw, FB_WORDS);
        finish_cmd(err, nw);

        // Reset on the 10th write cycle of a clear.
        w0 = writes_seen;
        issue(1'b1, 0, 0, 0, 0, 24'hABCDEF, err, nw);
        n = 0;
        while (writes_seen < w0 + 10 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached 10th write", writes_seen - w0, 10);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mem_wren after mid reset", bus.mem_wren, 0);
        chk("idle after mid reset", busy, 0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("ready after mid reset", bus.cmd_ready, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("no writes after mid reset", bus.mem_wren, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
